// File: rtl/constraint_sampler_pkg.sv
// Shared types and constants for the constraint sampler controller and its LFSR.
package constraint_sampler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } sampler_state_t;

  // Galois taps for x^64 + x^63 + x^61 + x^60 + 1, right-shifting form.
  localparam logic [63:0] LFSR_POLY     = 64'hD800_0000_0000_0000;
  localparam logic [63:0] LFSR_ZERO_SUB = 64'h1;

endpackage

// File: rtl/sampler_lfsr64.sv
// 64-bit Galois LFSR candidate source; a zero seed is replaced so the register never holds zero.
module sampler_lfsr64
  import constraint_sampler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] seed,
  input  logic        adv,
  output logic [63:0] state
);

  logic [63:0] next_state;

  always_comb begin
    next_state = {1'b0, state[63:1]} ^ (state[0] ? LFSR_POLY : 64'h0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LFSR_ZERO_SUB;
    end else if (load) begin
      state <= (seed == 64'h0) ? LFSR_ZERO_SUB : seed;
    end else if (adv) begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/constraint_sampler_ctrl.sv
// Drives a constraint checker with LFSR candidates and streams accepted ones out over valid/ready.
// Optional run statistics (tried_cnt) are built only when CONSTRAINT_SAMPLER_STATS_EN is defined.
module constraint_sampler_ctrl
  import constraint_sampler_pkg::*;
#(
  parameter int VEC_W     = 64,
  parameter int MAX_TRIES = 1024,
  parameter int TRY_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [63:0]      seed,
  input  logic [15:0]      req_count,
  output logic [VEC_W-1:0] cand_o,
  input  logic             chk_i,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic [VEC_W-1:0] sample_data,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [15:0]      accepted_cnt,
  output logic [TRY_W-1:0] tried_cnt
);

  sampler_state_t state, next;

  logic [63:0]      lfsr_state;
  logic             lfsr_load, lfsr_adv;
  logic             run_start, hit, miss, handshake, to_flag;
  logic [15:0]      req_q;
  logic [TRY_W-1:0] try_cnt;

  sampler_lfsr64 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .seed  (seed),
    .adv   (lfsr_adv),
    .state (lfsr_state)
  );

  assign cand_o = lfsr_state[VEC_W-1:0];
  assign busy   = (state == ST_GEN) || (state == ST_HOLD);
  assign done   = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next;
  end

  always_comb begin
    next      = state;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    run_start = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;
    handshake = 1'b0;
    to_flag   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          lfsr_load = 1'b1;
          run_start = 1'b1;
          next      = (req_count == 16'd0) ? ST_DONE : ST_GEN;
        end
      end
      ST_GEN: begin
        // A hit on the last allowed try takes priority over the timeout.
        if (chk_i) begin
          hit  = 1'b1;
          next = ST_HOLD;
        end else begin
          miss     = 1'b1;
          lfsr_adv = 1'b1;
          if (try_cnt == TRY_W'(MAX_TRIES - 1)) begin
            to_flag = 1'b1;
            next    = ST_DONE;
          end
        end
      end
      ST_HOLD: begin
        if (sample_ready) begin
          handshake = 1'b1;
          lfsr_adv  = 1'b1;
          next      = (accepted_cnt + 16'd1 == req_q) ? ST_DONE : ST_GEN;
        end
      end
      ST_DONE: next = ST_IDLE;
      default: next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q        <= '0;
      try_cnt      <= '0;
      accepted_cnt <= '0;
      timeout      <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
    end else begin
      if (run_start) begin
        req_q        <= req_count;
        try_cnt      <= '0;
        accepted_cnt <= '0;
        timeout      <= 1'b0;
      end
      if (hit) begin
        sample_data  <= cand_o;
        sample_valid <= 1'b1;
      end
      if (miss) begin
        try_cnt <= try_cnt + 1'b1;
        if (to_flag) timeout <= 1'b1;
      end
      if (handshake) begin
        sample_valid <= 1'b0;
        accepted_cnt <= accepted_cnt + 16'd1;
        try_cnt      <= '0;
      end
    end
  end

`ifdef CONSTRAINT_SAMPLER_STATS_EN
  logic [TRY_W-1:0] tried_q;

  function automatic logic [TRY_W-1:0] sat_inc(input logic [TRY_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)               tried_q <= '0;
    else if (run_start)    tried_q <= '0;
    else if (hit || miss)  tried_q <= sat_inc(tried_q);
  end

  assign tried_cnt = tried_q;
`else
  assign tried_cnt = '0;
`endif

endmodule
